// File: rtl/wide_add_seq.sv
// Serial wide adder/subtractor: one 32-bit slice per clock through a single
// adder32, least-significant slice first, with a registered carry between slices.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic [32:0] t;

    // 32-bit add with carry in; carry out taken from bit 32
    always_comb begin
        t    = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        s    = t[31:0];
        cout = t[32];
    end
endmodule

module wide_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WORDS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);
    localparam int unsigned W = 32 * WORDS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAST = 4'(WORDS - 1);

    logic [1:0]   state;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic         cy;
    logic [3:0]   k;

    logic [31:0]  sl_a;
    logic [31:0]  sl_b;
    logic [31:0]  sl_s;
    logic         sl_c;

    // Select operand slice k for the shared adder
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (k == 4'(i)) begin
                sl_a = a_reg[32*i +: 32];
                sl_b = b_reg[32*i +: 32];
            end
        end
    end

    adder32 u_add (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (cy),
        .s    (sl_s),
        .cout (sl_c)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Control FSM and datapath registers; subtraction is a + ~b + 1 with the
    // +1 injected through the initial carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cy        <= 1'b0;
            k         <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b ^ {W{sub}};
                        cy    <= sub;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < WORDS; i++) begin
                        if (k == 4'(i)) begin
                            sum[32*i +: 32] <= sl_s;
                        end
                    end
                    cy <= sl_c;
                    k  <= k + 4'd1;
                    if (k == LAST) begin
                        state     <= DONE;
                        carry_out <= sl_c;
                        overflow  <= ~(a_reg[W-1] ^ b_reg[W-1]) & (a_reg[W-1] ^ sl_s[31]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter WORDS, default 4: operand width in 32-bit words; legal range 1..8; data width W = 32*WORDS.
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port in_valid  input  1  operation request.
REQ-005 Port in_ready  output  1  block can accept a request.
REQ-006 Port a  input  W  first operand, unsigned or two's complement.
REQ-007 Port b  input  W  second operand.
REQ-008 Port sub  input  1  0 = a+b, 1 = a-b.
REQ-009 Port out_valid  output  1  result available.
REQ-010 Port out_ready  input  1  consumer takes result.
REQ-011 Port sum  output  W  result, modulo 2^W.
REQ-012 Port carry_out  output  1  carry out of bit W-1; for sub, 1 = no borrow (a >= b unsigned).
REQ-013 Port overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 The block SHALL compute the W-bit result serially using exactly one instance of adder32, one 32-bit slice per clock, least-significant slice first.
REQ-015 States: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on the edge where in_valid & in_ready, the block SHALL register a, b XOR {W{sub}}, and sub as the carry register; it SHALL clear the beat counter and enter RUN.
REQ-017 IDLE with in_valid = 0: remain in IDLE; operand registers unchanged.
REQ-018 RUN, beat k: adder32 inputs = a_reg slice k, b_reg slice k, carry register; on the edge, write the adder32 sum into sum slice k, load its carry into the carry register, and increment k.
REQ-019 RUN at k = WORDS-1: after that edge, enter DONE with carry_out = final carry and overflow = ~(a_reg[W-1] ^ b_reg[W-1]) & (a_reg[W-1] ^ sum[W-1]).
REQ-020 Latency: out_valid SHALL rise exactly WORDS edges after the accepting edge, independent of operand values (full carry ripple included).
REQ-021 DONE: sum, carry_out and overflow SHALL stay stable while out_ready = 0, for any number of cycles.
REQ-022 DONE with out_ready = 1: on that edge, go to IDLE; sum, carry_out and overflow keep their values until the next operation overwrites them.
REQ-023 in_valid while in RUN or DONE SHALL be ignored, with no effect on the operation or the registers.
REQ-024 No overlap: with out_ready tied high, the minimum spacing between accepting edges is WORDS+2 cycles.
REQ-025 The only carry path between slices is the registered carry; there is no combinational path from any input to any output other than through state.
REQ-026 WORDS = 1: RUN lasts one cycle; the result equals a single adder32 operation.

Reset
REQ-027 When rst is asserted, the block SHALL immediately enter IDLE with out_valid = 0, sum = 0, carry_out = 0, overflow = 0, beat counter = 0, carry register = 0; in_ready reads 1 while in IDLE.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no out_valid pulse; the first request after deassertion SHALL produce a correct result.

Verification
REQ-029 WORDS=4, a = all ones, b = 1, sub = 0 -> sum = 0, carry_out = 1, overflow = 0, out_valid exactly 4 edges after accept.
REQ-030 a = 5, b = 7, sub = 1 -> sum = 0xFFFF...FFFE (128 bits), carry_out = 0, overflow = 0; then a = 7, b = 5, sub = 1 -> sum = 2, carry_out = 1.
REQ-031 a = 0x7FFF...FFFF, b = 1, sub = 0 -> sum = 0x8000...0000, overflow = 1, carry_out = 0; a = 0x8000...0000, b = 1, sub = 1 -> sum = 0x7FFF...FFFF, overflow = 1.
REQ-032 Backpressure: hold out_ready = 0 for 10 cycles in DONE while pulsing in_valid with new operands -> out_valid, sum and flags held, in_ready = 0, new operands ignored; release -> IDLE next cycle.
REQ-033 Assert rst asynchronously mid-cycle at beat 2 of RUN -> outputs clear without waiting for an edge, no out_valid; next request a = 1, b = 2 -> sum = 3.
REQ-034 Random add/sub operands checked against a W-bit reference model, with out_ready held high, for WORDS = 1, 4 and 8 -> all results match; accept-to-accept spacing = WORDS+2 cycles.
